// File: rtl/vpu_req_sink.sv
// Consumer end of the VPU decoded-request channel: one instruction in flight,
// sequenced through SRAM read, execution launch/delay and SRAM write-back.
module vpu_req_sink #(
    parameter int SRAM_R_PORT_CNT = 3,
    parameter int ADDR_W          = 10,
    parameter int MAX_DELAY_LG2   = 4,
    parameter int OPCODE_W        = 6,
    parameter int OPFUNC_W        = 32,
    parameter int SRAM_RD_LAT     = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [SRAM_R_PORT_CNT-1:0]        req_rvalid_i,
    input  logic [SRAM_R_PORT_CNT*ADDR_W-1:0] req_raddr_i,
    input  logic [ADDR_W-1:0]                 req_waddr_i,
    input  logic [MAX_DELAY_LG2-1:0]          req_delay_i,
    input  logic [OPCODE_W-1:0]               req_opcode_i,
    input  logic [OPFUNC_W-1:0]               req_op_func_i,
    output logic [SRAM_R_PORT_CNT-1:0]        sram_ren_o,
    output logic [SRAM_R_PORT_CNT*ADDR_W-1:0] sram_raddr_o,
    output logic                              exec_start_o,
    output logic [OPCODE_W-1:0]               exec_opcode_o,
    output logic [OPFUNC_W-1:0]               exec_op_func_o,
    output logic                              sram_wen_o,
    output logic [ADDR_W-1:0]                 sram_waddr_o,
    output logic                              done_o,
    output logic                              busy_o
);

    localparam int CNT_W = MAX_DELAY_LG2;
    // The shared counter also times the read wait, so SRAM_RD_LAT-1 must fit in CNT_W bits.
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(SRAM_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RD,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]                  cnt;
    logic [CNT_W-1:0]                  exec_last;
    logic [SRAM_R_PORT_CNT-1:0]        rvalid_q;
    logic [SRAM_R_PORT_CNT*ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0]                 waddr_q;
    logic [MAX_DELAY_LG2-1:0]          delay_q;
    logic [OPCODE_W-1:0]               opcode_q;
    logic [OPFUNC_W-1:0]               op_func_q;
    logic                              accept;

    assign accept    = (state == S_IDLE) && req_valid_i;
    // A delay of 0 behaves as 1, so the last EXEC count is max(delay,1)-1.
    assign exec_last = (delay_q == '0) ? '0 : delay_q - CNT_W'(1);

    // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (req_valid_i) next_state = (req_rvalid_i != '0) ? S_READ : S_EXEC;
            S_READ:    next_state = S_WAIT_RD;
            S_WAIT_RD: if (cnt == RD_LAST) next_state = S_EXEC;
            S_EXEC:    if (cnt == exec_last) next_state = S_WRITE;
            S_WRITE:   next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rvalid_q  <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            delay_q   <= '0;
            opcode_q  <= '0;
            op_func_q <= '0;
        end else begin
            state <= next_state;
            // Counter restarts on every state change and holds at 0 in IDLE, so it never wraps.
            if (next_state != state || state == S_IDLE) cnt <= '0;
            else                                        cnt <= cnt + CNT_W'(1);
            if (accept) begin
                rvalid_q  <= req_rvalid_i;
                raddr_q   <= req_raddr_i;
                waddr_q   <= req_waddr_i;
                delay_q   <= req_delay_i;
                opcode_q  <= req_opcode_i;
                op_func_q <= req_op_func_i;
            end
        end
    end

    // Strobes are suppressed while rst is high so a reset cycle never fires a read or write.
    assign req_ready_o    = (state == S_IDLE) && !rst;
    assign sram_ren_o     = (state == S_READ && !rst) ? rvalid_q : '0;
    assign exec_start_o   = (state == S_EXEC) && (cnt == '0) && !rst;
    assign sram_wen_o     = (state == S_WRITE) && !rst;
    assign done_o         = sram_wen_o;
    assign sram_waddr_o   = sram_wen_o ? waddr_q : '0;
    assign busy_o         = (state != S_IDLE);
    assign exec_opcode_o  = opcode_q;
    assign exec_op_func_o = op_func_q;

    always_comb begin
        sram_raddr_o = '0;
        for (int k = 0; k < SRAM_R_PORT_CNT; k++) begin
            if (sram_ren_o[k]) sram_raddr_o[k*ADDR_W +: ADDR_W] = raddr_q[k*ADDR_W +: ADDR_W];
        end
    end

endmodule

// File: tb/tb_vpu_req_sink.sv
// Scoreboard bench for vpu_req_sink: a timeline model predicts every output per cycle
// from the accept cycle, read latency and effective delay of each instruction.
module tb_vpu_req_sink;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 4;
    localparam int OW = 6;
    localparam int FW = 32;
    localparam int L  = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [N-1:0]    req_rvalid_i;
    logic [N*AW-1:0] req_raddr_i;
    logic [AW-1:0]   req_waddr_i;
    logic [DW-1:0]   req_delay_i;
    logic [OW-1:0]   req_opcode_i;
    logic [FW-1:0]   req_op_func_i;
    logic [N-1:0]    sram_ren_o;
    logic [N*AW-1:0] sram_raddr_o;
    logic            exec_start_o;
    logic [OW-1:0]   exec_opcode_o;
    logic [FW-1:0]   exec_op_func_o;
    logic            sram_wen_o;
    logic [AW-1:0]   sram_waddr_o;
    logic            done_o;
    logic            busy_o;

    always #5 clk = ~clk;

    vpu_req_sink #(
        .SRAM_R_PORT_CNT(N), .ADDR_W(AW), .MAX_DELAY_LG2(DW),
        .OPCODE_W(OW), .OPFUNC_W(FW), .SRAM_RD_LAT(L)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rvalid_i(req_rvalid_i), .req_raddr_i(req_raddr_i),
        .req_waddr_i(req_waddr_i), .req_delay_i(req_delay_i),
        .req_opcode_i(req_opcode_i), .req_op_func_i(req_op_func_i),
        .sram_ren_o(sram_ren_o), .sram_raddr_o(sram_raddr_o),
        .exec_start_o(exec_start_o), .exec_opcode_o(exec_opcode_o),
        .exec_op_func_o(exec_op_func_o), .sram_wen_o(sram_wen_o),
        .sram_waddr_o(sram_waddr_o), .done_o(done_o), .busy_o(busy_o)
    );

    // Expected lifetime of one accepted instruction, in absolute cycle numbers.
    typedef struct {
        int              t_acc;
        int              t_ren;
        int              t_start;
        int              t_wen;
        logic [N-1:0]    rvalid;
        logic [N*AW-1:0] raddr;
        logic [AW-1:0]   waddr;
        logic [OW-1:0]   opcode;
        logic [FW-1:0]   op_func;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   free_at = 0;
    int   acc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc + 1, act, exp_v);
        end
    endtask

    // Model side: decides acceptance from the sampled inputs and pushes the expected timeline.
    initial begin
        exp_t r;
        int   d;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                sb.delete();
                free_at = cyc + 1;
            end else if (req_valid_i && cyc >= free_at) begin
                d         = (req_delay_i == 0) ? 1 : int'(req_delay_i);
                r.t_acc   = cyc;
                r.rvalid  = req_rvalid_i;
                r.raddr   = req_raddr_i;
                r.waddr   = req_waddr_i;
                r.opcode  = req_opcode_i;
                r.op_func = req_op_func_i;
                if (req_rvalid_i != 0) begin
                    r.t_ren   = cyc + 1;
                    r.t_start = cyc + 2 + L;
                end else begin
                    r.t_ren   = -1;
                    r.t_start = cyc + 1;
                end
                r.t_wen = r.t_start + d;
                free_at = r.t_wen + 1;
                sb.push_back(r);
                acc_cnt++;
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the front scoreboard entry.
    initial begin
        int              n;
        logic            has;
        logic            busy_e;
        logic [N-1:0]    ren_e;
        logic [N*AW-1:0] raddr_e;
        logic            start_e;
        logic            wen_e;
        logic [AW-1:0]   waddr_e;
        exp_t            r;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                n       = cyc + 1;
                has     = (sb.size() > 0);
                busy_e  = (n < free_at);
                ren_e   = '0;
                raddr_e = '0;
                start_e = 1'b0;
                wen_e   = 1'b0;
                waddr_e = '0;
                if (has) begin
                    r = sb[0];
                    if (!rst && n == r.t_ren) begin
                        ren_e = r.rvalid;
                        for (int k = 0; k < N; k++)
                            if (r.rvalid[k]) raddr_e[k*AW +: AW] = r.raddr[k*AW +: AW];
                    end
                    start_e = !rst && (n == r.t_start);
                    if (!rst && n == r.t_wen) begin
                        wen_e   = 1'b1;
                        waddr_e = r.waddr;
                    end
                    if (n >= r.t_start && n <= r.t_wen) begin
                        check("exec_opcode", exec_opcode_o, r.opcode);
                        check("exec_op_func", exec_op_func_o, r.op_func);
                    end
                end
                check("busy", busy_o, busy_e);
                check("ready", req_ready_o, !rst && !busy_e);
                check("ren", sram_ren_o, ren_e);
                check("raddr", sram_raddr_o, raddr_e);
                check("exec_start", exec_start_o, start_e);
                check("wen", sram_wen_o, wen_e);
                check("done", done_o, wen_e);
                check("waddr", sram_waddr_o, waddr_e);
                if (has && n == r.t_wen) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0] rv, input logic [N*AW-1:0] ra, input logic [AW-1:0] wa,
                        input logic [DW-1:0] dl, input logic hold);
        int   start;
        int   waited;
        logic [31:0] rnd;
        rnd           = $urandom;
        req_valid_i   = 1'b1;
        req_rvalid_i  = rv;
        req_raddr_i   = ra;
        req_waddr_i   = wa;
        req_delay_i   = dl;
        req_opcode_i  = rnd[OW-1:0];
        req_op_func_i = $urandom;
        start         = acc_cnt;
        waited        = 0;
        while (acc_cnt == start && waited < 64) begin
            tick();
            waited++;
        end
        check("accept_in_time", acc_cnt != start, 1'b1);
        if (!hold) begin
            req_valid_i = 1'b0;
            rnd         = $urandom;
            req_waddr_i = rnd[AW-1:0];
            req_delay_i = rnd[DW+AW-1:AW];
        end
    endtask

    task automatic wait_idle();
        int waited = 0;
        while (cyc + 1 < free_at && waited < 64) begin
            tick();
            waited++;
        end
        tick();
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        rst           = 1'b1;
        req_valid_i   = 1'b0;
        req_rvalid_i  = '0;
        req_raddr_i   = '0;
        req_waddr_i   = '0;
        req_delay_i   = '0;
        req_opcode_i  = '0;
        req_op_func_i = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_ready_low", req_ready_o, 1'b0);
        check("reset_busy", busy_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", req_ready_o, 1'b1);
        check("post_reset_opcode", exec_opcode_o, '0);
        check("post_reset_op_func", exec_op_func_o, '0);
        @(posedge clk); #1;

        // Three-operand, single-operand, then two back-to-back requests with valid held.
        send(3'b111, {10'h30, 10'h20, 10'h10}, 10'h55, 4'd2, 1'b0);
        wait_idle();
        send(3'b001, {10'h3a1, 10'h2b2, 10'h1c3}, 10'h0aa, 4'd2, 1'b0);
        wait_idle();
        send(3'b011, {10'h111, 10'h222, 10'h333}, 10'h123, 4'd2, 1'b1);
        send(3'b110, {10'h044, 10'h055, 10'h066}, 10'h321, 4'd1, 1'b0);
        wait_idle();

        // Delay corners and the no-operand path.
        send(3'b101, {10'h001, 10'h002, 10'h003}, 10'h3ff, 4'd0, 1'b0);
        wait_idle();
        send(3'b111, {10'h3ff, 10'h3fe, 10'h3fd}, 10'h200, 4'd15, 1'b0);
        wait_idle();
        send(3'b000, {10'h155, 10'h0aa, 10'h3c3}, 10'h077, 4'd3, 1'b0);
        wait_idle();

        // Reset while in EXEC: the instruction is dropped and no write-back follows.
        send(3'b111, {10'h010, 10'h020, 10'h030}, 10'h0f0, 4'd10, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("midrst_ready", req_ready_o, 1'b0);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_wen", sram_wen_o, 1'b0);
        check("midrst_opcode", exec_opcode_o, '0);
        check("midrst_op_func", exec_op_func_o, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", req_ready_o, 1'b1);
        @(posedge clk); #1;
        repeat (16) tick();

        // Random traffic, sometimes held back-to-back, sometimes with idle gaps.
        for (int i = 0; i < 60; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            send(r1[2:0], {r2[29:0]}, r1[12:3], r1[16:13], r1[18:17] != 2'b00);
            if (!req_valid_i) repeat (int'(r1[20:19])) tick();
        end
        req_valid_i = 1'b0;
        repeat (25) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
